// File: rtl/power_seq_ctrl.sv
// Multi-domain power sequencer: per-domain iso/retention/switch FSMs with single-domain in-rush grant.
// Optional macro PSW_ACK_EN adds a synchronised psw_ack handshake on PWR_UP/PWR_DN.
module power_seq_ctrl #(
  parameter int NUM_DOMAINS = 2,
  parameter int CNT_W       = 4,
  parameter int ISO_DLY     = 1,
  parameter int RET_DLY     = 1,
  parameter int PSW_DLY     = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_DOMAINS-1:0] mode,
  input  logic [NUM_DOMAINS-1:0] mode_req,
`ifdef PSW_ACK_EN
  input  logic [NUM_DOMAINS-1:0] psw_ack,
`endif
  output logic [NUM_DOMAINS-1:0] mode_ack,
  output logic [NUM_DOMAINS-1:0] iso_en,
  output logic [NUM_DOMAINS-1:0] ret_save,
  output logic [NUM_DOMAINS-1:0] ret_restore,
  output logic [NUM_DOMAINS-1:0] sw_disable,
  output logic [NUM_DOMAINS-1:0] busy
);

  typedef enum logic [3:0] {
    S_ON, S_ISO, S_SAVE, S_PWR_DN, S_OFF, S_PEND, S_PWR_UP, S_RESTORE, S_UNISO
  } state_t;

  // Counters load DLY-1 on entry so a phase lasts exactly DLY cycles.
  localparam logic [CNT_W-1:0] ISO_LD = CNT_W'(ISO_DLY - 1);
  localparam logic [CNT_W-1:0] RET_LD = CNT_W'(RET_DLY - 1);
  localparam logic [CNT_W-1:0] PSW_LD = CNT_W'(PSW_DLY - 1);

  state_t                 state_p0 [NUM_DOMAINS];
  state_t                 state_nxt[NUM_DOMAINS];
  logic [CNT_W-1:0]       cnt_p0   [NUM_DOMAINS];
  logic [CNT_W-1:0]       cnt_nxt  [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] ack_evt_p0;
  logic [NUM_DOMAINS-1:0] ack_evt_nxt;
  logic [NUM_DOMAINS-1:0] grant;
  logic                   up_taken;
  logic [NUM_DOMAINS-1:0] psw_on_ok;
  logic [NUM_DOMAINS-1:0] psw_off_ok;

`ifdef PSW_ACK_EN
  logic [NUM_DOMAINS-1:0] psw_sync_p0;
  logic [NUM_DOMAINS-1:0] psw_sync_p1;

  // Stage p0/p1: two-flop synchroniser for the switch acknowledge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psw_sync_p0 <= '0;
      psw_sync_p1 <= '0;
    end else begin
      psw_sync_p0 <= psw_ack;
      psw_sync_p1 <= psw_sync_p0;
    end
  end

  assign psw_on_ok  = psw_sync_p1;
  assign psw_off_ok = ~psw_sync_p1;
`else
  assign psw_on_ok  = '1;
  assign psw_off_ok = '1;
`endif

  // In-rush arbiter: grant the lowest-index PEND domain only when nobody is ramping.
  always_comb begin
    grant    = '0;
    up_taken = 1'b0;
    for (int i = 0; i < NUM_DOMAINS; i++)
      if (state_p0[i] == S_PWR_UP) up_taken = 1'b1;
    for (int i = 0; i < NUM_DOMAINS; i++)
      if (!up_taken && state_p0[i] == S_PEND) begin
        grant[i] = 1'b1;
        up_taken = 1'b1;
      end
  end

  always_comb begin
    ack_evt_nxt = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      state_nxt[i] = state_p0[i];
      cnt_nxt[i]   = (cnt_p0[i] == '0) ? '0 : cnt_p0[i] - 1'b1;
      case (state_p0[i])
        S_ON:
          if (mode_req[i]) begin
            if (!mode[i]) begin
              state_nxt[i] = S_ISO;
              cnt_nxt[i]   = ISO_LD;
            end else begin
              ack_evt_nxt[i] = 1'b1;
            end
          end
        S_ISO:
          if (cnt_p0[i] == '0) begin
            state_nxt[i] = S_SAVE;
            cnt_nxt[i]   = RET_LD;
          end
        S_SAVE:
          if (cnt_p0[i] == '0) begin
            state_nxt[i] = S_PWR_DN;
            cnt_nxt[i]   = PSW_LD;
          end
        S_PWR_DN:
          if (cnt_p0[i] == '0 && psw_off_ok[i]) begin
            state_nxt[i]   = S_OFF;
            ack_evt_nxt[i] = 1'b1;
          end
        S_OFF:
          if (mode_req[i]) begin
            if (mode[i]) state_nxt[i] = S_PEND;
            else         ack_evt_nxt[i] = 1'b1;
          end
        S_PEND:
          if (grant[i]) begin
            state_nxt[i] = S_PWR_UP;
            cnt_nxt[i]   = PSW_LD;
          end
        S_PWR_UP:
          if (cnt_p0[i] == '0 && psw_on_ok[i]) begin
            state_nxt[i] = S_RESTORE;
            cnt_nxt[i]   = RET_LD;
          end
        S_RESTORE:
          if (cnt_p0[i] == '0) begin
            state_nxt[i] = S_UNISO;
            cnt_nxt[i]   = ISO_LD;
          end
        S_UNISO:
          if (cnt_p0[i] == '0) begin
            state_nxt[i]   = S_ON;
            ack_evt_nxt[i] = 1'b1;
          end
        default: state_nxt[i] = S_ON;
      endcase
    end
  end

  // Stage p0: per-domain state, phase counter and completion event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        state_p0[i] <= S_ON;
        cnt_p0[i]   <= '0;
      end
      ack_evt_p0 <= '0;
    end else begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        state_p0[i] <= state_nxt[i];
        cnt_p0[i]   <= cnt_nxt[i];
      end
      ack_evt_p0 <= ack_evt_nxt;
    end
  end

  // Stage p1: registered output decode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_ack    <= '0;
      iso_en      <= '0;
      ret_save    <= '0;
      ret_restore <= '0;
      sw_disable  <= '0;
      busy        <= '0;
    end else begin
      mode_ack <= ack_evt_p0;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        iso_en[i]      <= (state_p0[i] != S_ON);
        ret_save[i]    <= (state_p0[i] == S_SAVE);
        ret_restore[i] <= (state_p0[i] == S_RESTORE);
        sw_disable[i]  <= (state_p0[i] == S_PWR_DN) || (state_p0[i] == S_OFF) ||
                          (state_p0[i] == S_PEND);
        busy[i]        <= (state_p0[i] != S_ON) && (state_p0[i] != S_OFF);
      end
    end
  end

endmodule

// File: tb/tb_power_seq_ctrl.sv
// Testbench for power_seq_ctrl (NUM_DOMAINS=2, default delays): vector table with scoreboard plus
// hand sequences for reset, mid-sequence reset and the optional psw_ack handshake.
module tb_power_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] mode = '0;
  logic [1:0] mode_req = '0;
  logic [1:0] psw_ack = '0;
  logic [1:0] mode_ack, iso_en, ret_save, ret_restore, sw_disable, busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] req, mode;
    logic [1:0] iso, save, rest, sw, busy, ack;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  power_seq_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode        (mode),
    .mode_req    (mode_req),
`ifdef PSW_ACK_EN
    .psw_ack     (psw_ack),
`endif
    .mode_ack    (mode_ack),
    .iso_en      (iso_en),
    .ret_save    (ret_save),
    .ret_restore (ret_restore),
    .sw_disable  (sw_disable),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] req, input logic [1:0] md, input logic [1:0] iso,
                     input logic [1:0] save, input logic [1:0] rest, input logic [1:0] sw,
                     input logic [1:0] bsy, input logic [1:0] ack);
    vec_t v;
    v.req = req; v.mode = md; v.iso = iso; v.save = save;
    v.rest = rest; v.sw = sw; v.busy = bsy; v.ack = ack;
    vecs.push_back(v);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, mode_ack, 2'b00);
    chk({tag, "_iso"}, iso_en, 2'b00);
    chk({tag, "_save"}, ret_save, 2'b00);
    chk({tag, "_rest"}, ret_restore, 2'b00);
    chk({tag, "_sw"}, sw_disable, 2'b00);
    chk({tag, "_busy"}, busy, 2'b00);
  endtask

  // Scoreboard: outputs checked 1 time unit after the edge that consumed the vector
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      chk("tbl_ack", mode_ack, e.ack);
      chk("tbl_iso", iso_en, e.iso);
      chk("tbl_save", ret_save, e.save);
      chk("tbl_rest", ret_restore, e.rest);
      chk("tbl_sw", sw_disable, e.sw);
      chk("tbl_busy", busy, e.busy);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    //      req    mode   iso    save   rest   sw     busy   ack
    // domain 0 power-down; request during SAVE is ignored
    add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00);
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00);
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    // redundant requests: d0 off->off, d1 on->on
    add(2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b11);
    // domain 0 power-up
    add(2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00);
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00);
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // both domains down together
    add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    add(2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    add(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00);
    add(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00);
    add(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11);
    add(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    // both up together: d0 ramps first, d1 held in PEND
    add(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00);
    add(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00);
    add(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00);
    add(2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00);
    add(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    add(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01);
    add(2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00);
    add(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Reset state
    repeat (2) @(posedge clk);
    #1 chk_all_zero("in_reset");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1 chk_all_zero("post_reset");

`ifndef PSW_ACK_EN
    foreach (vecs[k]) begin
      @(negedge clk);
      mode_req = vecs[k].req;
      mode     = vecs[k].mode;
      sb.push_back(vecs[k]);
    end
    @(negedge clk);
    mode_req = '0;
    mode     = '0;
    @(posedge clk);
    #2;
    chk("sb_drained", 2'(sb.size()), 2'b00);
`endif

    // Asynchronous reset while domain 0 is in PWR_DN
    @(negedge clk);
    mode_req = 2'b01;
    mode     = 2'b00;
    @(posedge clk);
    #1 mode_req = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_sw", sw_disable, 2'b01);
    chk("pre_rst_iso", iso_en, 2'b01);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1 chk_all_zero("rst_release");
    // Domain must be back in ON: a mode=1 request is redundant and only acks
    @(negedge clk);
    mode_req = 2'b01;
    mode     = 2'b01;
    @(posedge clk);
    #1;
    mode_req = '0;
    chk("redund_ack0", mode_ack, 2'b00);
    @(posedge clk);
    #1;
    chk("redund_ack1", mode_ack, 2'b01);
    chk("redund_iso", iso_en, 2'b00);
    chk("redund_sw", sw_disable, 2'b00);

`ifdef PSW_ACK_EN
    // psw_ack held low: power-down completes, power-up stalls in PWR_UP
    psw_ack = 2'b00;
    @(negedge clk);
    mode_req = 2'b01;
    mode     = 2'b00;
    @(posedge clk);
    #1 mode_req = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("ack_dn_ack", mode_ack, 2'b01);
    chk("ack_dn_sw", sw_disable, 2'b01);
    @(negedge clk);
    mode_req = 2'b01;
    mode     = 2'b01;
    @(posedge clk);
    #1 mode_req = '0;
    repeat (15) @(posedge clk);
    #1;
    chk("stall_sw", sw_disable, 2'b00);
    chk("stall_busy", busy, 2'b01);
    chk("stall_rest", ret_restore, 2'b00);
    @(negedge clk) psw_ack = 2'b01;
    repeat (3) @(posedge clk);
    #1 chk("ack_rest_early", ret_restore, 2'b00);
    @(posedge clk);
    #1 chk("ack_rest", ret_restore, 2'b01);
    repeat (2) @(posedge clk);
    #1;
    chk("ack_up_ack", mode_ack, 2'b01);
    chk("ack_up_iso", iso_en, 2'b00);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
